// File: rtl/psram_responder.sv
`default_nettype none
// ============================================================================
// Module   : psram_responder
// Purpose  : Asynchronous-mode PSRAM target with a 2^AW x 16 backing store.
//            Defining PSRAM_RSP_ERRCHK_EN builds in the sticky protocol checker.
// Revision : 1.0  initial release
// ============================================================================
module psram_responder #(
    parameter int AW     = 10,
    parameter int RD_LAT = 2,
    parameter int WR_MIN = 3
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        PSRAM_CLK,
    input  logic        PSRAM_ADV_N,
    input  logic        PSRAM_CE_N,
    input  logic        PSRAM_OE_N,
    input  logic        PSRAM_WE_N,
    input  logic        PSRAM_LB_N,
    input  logic        PSRAM_UB_N,
    input  logic [22:0] PSRAM_ADDR,
    input  logic [15:0] PSRAM_DQ_I,
    output logic [15:0] PSRAM_DQ_O,
    output logic        PSRAM_DQ_OE,
    output logic [15:0] ACC_CNT,
    output logic        ERR
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_WAIT   = 2'd1,
        RD_DRIVE  = 2'd2,
        WR_ACTIVE = 2'd3
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

    // Sampled pin stage
    logic        clk_q;
    logic        adv_q;
    logic        ce_q;
    logic        oe_q;
    logic        we_q;
    logic        lb_q;
    logic        ub_q;
    logic [22:0] addr_q;
    logic [15:0] dq_q;

    // FSM and tracking registers
    state_t          state_q;
    logic [3:0]      lat_q;
    logic [AW-1:0]   rd_addr_q;
    logic [AW-1:0]   wa_q;
    logic [15:0]     wd_q;
    logic            wlb_q;
    logic            wub_q;
    logic [3:0]      wcnt_q;
    logic [15:0]     dq_o_q;
    logic            dq_oe_q;
    logic [15:0]     acc_q;

    logic [15:0]     mem_q [0:(1<<AW)-1];

    logic [AW-1:0]   idx;
    logic            wr_commit;
    logic            unused_ok;

    function automatic logic [15:0] lane_mask(input logic [15:0] w,
                                              input logic        lb_n,
                                              input logic        ub_n);
        return {(ub_n ? 8'h00 : w[15:8]), (lb_n ? 8'h00 : w[7:0])};
    endfunction

    assign idx       = addr_q[AW-1:0];
    assign wr_commit = (state_q == WR_ACTIVE) && (we_q || ce_q);
    assign unused_ok = ^{clk_q, adv_q, addr_q[22:AW]};

    // Reset parks the sample stage at idle pin levels so no access is seen.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            clk_q  <= 1'b1;
            adv_q  <= 1'b1;
            ce_q   <= 1'b1;
            oe_q   <= 1'b1;
            we_q   <= 1'b1;
            lb_q   <= 1'b1;
            ub_q   <= 1'b1;
            addr_q <= '1;
            dq_q   <= '1;
        end else begin
            clk_q  <= PSRAM_CLK;
            adv_q  <= PSRAM_ADV_N;
            ce_q   <= PSRAM_CE_N;
            oe_q   <= PSRAM_OE_N;
            we_q   <= PSRAM_WE_N;
            lb_q   <= PSRAM_LB_N;
            ub_q   <= PSRAM_UB_N;
            addr_q <= PSRAM_ADDR;
            dq_q   <= PSRAM_DQ_I;
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q   <= IDLE;
            lat_q     <= 4'd0;
            rd_addr_q <= '0;
            wa_q      <= '0;
            wd_q      <= 16'h0000;
            wlb_q     <= 1'b1;
            wub_q     <= 1'b1;
            wcnt_q    <= 4'd0;
            dq_o_q    <= 16'h0000;
            dq_oe_q   <= 1'b0;
            acc_q     <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!ce_q && !we_q) begin
                        state_q <= WR_ACTIVE;
                        wa_q    <= idx;
                        wd_q    <= dq_q;
                        wlb_q   <= lb_q;
                        wub_q   <= ub_q;
                        wcnt_q  <= 4'd1;
                    end else if (!ce_q && !oe_q) begin
                        state_q   <= RD_WAIT;
                        rd_addr_q <= idx;
                        lat_q     <= LAT_LOAD;
                    end
                end
                RD_WAIT: begin
                    if (ce_q || oe_q) begin
                        state_q <= IDLE;
                    end else if (lat_q == 4'd0) begin
                        state_q <= RD_DRIVE;
                        dq_oe_q <= 1'b1;
                        dq_o_q  <= lane_mask(mem_q[rd_addr_q], lb_q, ub_q);
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                RD_DRIVE: begin
                    if (ce_q || oe_q) begin
                        state_q <= IDLE;
                        dq_oe_q <= 1'b0;
                        dq_o_q  <= 16'h0000;
                        acc_q   <= acc_q + 16'd1;
                    end else begin
                        dq_o_q <= lane_mask(mem_q[idx], lb_q, ub_q);
                    end
                end
                WR_ACTIVE: begin
                    if (wr_commit) begin
                        state_q <= IDLE;
                        acc_q   <= acc_q + 16'd1;
                    end else begin
                        wa_q  <= idx;
                        wd_q  <= dq_q;
                        wlb_q <= lb_q;
                        wub_q <= ub_q;
                        if (wcnt_q != 4'hF) begin
                            wcnt_q <= wcnt_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Store is deliberately left out of reset; a reset mid-write forces IDLE so nothing commits.
    always_ff @(posedge CLK) begin
        if (wr_commit) begin
            if (!wlb_q) begin
                mem_q[wa_q][7:0] <= wd_q[7:0];
            end
            if (!wub_q) begin
                mem_q[wa_q][15:8] <= wd_q[15:8];
            end
        end
    end

`ifdef PSRAM_RSP_ERRCHK_EN
    logic err_q;
    logic bus_clash;
    logic short_wr;

    assign bus_clash = !ce_q && !oe_q && !we_q;
    assign short_wr  = wr_commit && (int'(wcnt_q) < WR_MIN);

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            err_q <= 1'b0;
        end else if (bus_clash || short_wr) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign PSRAM_DQ_O  = dq_o_q;
    assign PSRAM_DQ_OE = dq_oe_q;
    assign ACC_CNT     = acc_q;

endmodule
`default_nettype wire
